// File: rtl/demux1_4_stream.sv
// demux1_4_stream: registered 1-to-4 valid/ready stream demultiplexer.
// A packet's destination lane comes from s_sel on its first beat and is held
// until the last beat. The output holds one registered beat and can refill it
// on the same edge it drains, so it sustains one beat per clock.
// Optional build macro: DEMUX_CNT_EN adds per-lane output-handshake counters
// on cnt_flat. Without the macro, cnt_flat is tied to zero.
module demux1_4_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic [1:0]           s_sel,
  input  logic                 s_last,
  output logic [3:0]           m_valid,
  input  logic [3:0]           m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_last,
  output logic [4*CNT_W-1:0]   cnt_flat
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  lane;
  logic [1:0]  lane_nx;
  logic [1:0]  dest;
  logic        full;
  logic        accept;
  logic        drain;

  // Handshake terms. s_ready depends only on the output register and the
  // ready of the lane it occupies, so there is no s_valid-to-s_ready path.
  always_comb begin
    full    = |m_valid;
    s_ready = !full || m_ready[lane];
    accept  = s_valid && s_ready;
    drain   = full && m_ready[lane];
    dest    = (state == IDLE) ? s_sel : lane;
  end

  // Next-state logic: a first beat latches the lane and, unless it is also
  // the last beat, locks the FSM until the packet's last beat is accepted.
  always_comb begin
    state_nx = state;
    lane_nx  = lane;
    if (accept) begin
      unique case (state)
        IDLE: begin
          lane_nx  = s_sel;
          state_nx = s_last ? IDLE : LOCKED;
        end
        LOCKED: begin
          if (s_last) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM state and latched lane registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane  <= 2'd0;
    end else begin
      state <= state_nx;
      lane  <= lane_nx;
    end
  end

  // Output register. An accepted beat takes priority over a drain, which
  // gives the bubble-free reload when both happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= '0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (accept) begin
      m_valid <= 4'b0001 << dest;
      m_data  <= s_data;
      m_last  <= s_last;
    end else if (drain) begin
      m_valid <= '0;
    end
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt [4];

  // Per-lane beat counters, one increment per output handshake, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (m_valid[i] && m_ready[i]) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Flatten the counters with lane 0 in the least significant bits.
  always_comb begin
    cnt_flat = '0;
    for (int unsigned i = 0; i < 4; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  // Counters are not built in this configuration.
  always_comb begin
    cnt_flat = '0;
  end
`endif

endmodule

// File: tb/tb_demux1_4_stream.sv
// Testbench for demux1_4_stream. It keeps a slot-and-packet reference model
// that advances once per clock, runs the directed scenarios, and then runs
// a long randomized sequence.
module tb_demux1_4_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [DATA_W-1:0]  s_data;
  logic [1:0]         s_sel;
  logic               s_last;
  logic [3:0]         m_valid;
  logic [3:0]         m_ready;
  logic [DATA_W-1:0]  m_data;
  logic               m_last;
  logic [4*CNT_W-1:0] cnt_flat;

  int n_tests = 0;
  int n_fail  = 0;

  demux1_4_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sel(s_sel), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .cnt_flat(cnt_flat)
  );

  always #5 clk = ~clk;

  // Reference model: one holding slot plus the lane of the open packet.
  logic              mfull = 1'b0;
  logic [1:0]        mslot_lane = 2'd0;
  logic [DATA_W-1:0] mdata = '0;
  logic              mlast = 1'b0;
  logic              min_pkt = 1'b0;
  logic [1:0]        mpkt_lane = 2'd0;
  logic [CNT_W-1:0]  mc [4] = '{default: '0};

  function automatic logic [3:0] exp_valid();
    return mfull ? (4'b0001 << mslot_lane) : 4'b0000;
  endfunction

  function automatic logic exp_ready();
    return !mfull || m_ready[mslot_lane];
  endfunction

  function automatic logic [4*CNT_W-1:0] exp_cnt();
    logic [4*CNT_W-1:0] v;
    v = '0;
`ifdef DEMUX_CNT_EN
    for (int i = 0; i < 4; i++) v[i*CNT_W +: CNT_W] = mc[i];
`endif
    return v;
  endfunction

  // Advance one clock. The model samples the inputs at the rising edge and
  // the bench resumes at the falling edge.
  task automatic tick();
    logic rdy, acc, drn;
    logic [1:0] dst;
    @(posedge clk);
    if (rst) begin
      mfull = 1'b0; mslot_lane = 2'd0; mdata = '0; mlast = 1'b0;
      min_pkt = 1'b0; mpkt_lane = 2'd0;
      for (int i = 0; i < 4; i++) mc[i] = '0;
    end else begin
      rdy = !mfull || m_ready[mslot_lane];
      acc = s_valid && rdy;
      drn = mfull && m_ready[mslot_lane];
      if (drn) mc[mslot_lane] = mc[mslot_lane] + CNT_W'(1);
      dst = min_pkt ? mpkt_lane : s_sel;
      if (acc) begin
        mfull = 1'b1; mslot_lane = dst; mdata = s_data; mlast = s_last;
        min_pkt = !s_last; mpkt_lane = dst;
      end else if (drn) begin
        mfull = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [1:0] sel, input logic l);
    s_valid = v; s_data = d; s_sel = sel; s_last = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 4'hF; drive(1'b0, '0, 2'd0, 1'b0);
    tick(); tick();
    #1;
    n_tests++; if (m_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0000", m_valid); end
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    n_tests++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    n_tests++; if (cnt_flat !== '0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", cnt_flat); end
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    m_ready = 4'hF; drive(1'b1, 8'hA5, 2'd2, 1'b1);
    tick();
    drive(1'b0, '0, 2'd0, 1'b0);
    #1;
    n_tests++; if (m_valid !== 4'b0100) begin n_fail++; $display("FAIL single_m_valid got=%b exp=0100", m_valid); end
    n_tests++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL single_m_data got=%h exp=a5", m_data); end
    n_tests++; if (m_last !== 1'b1) begin n_fail++; $display("FAIL single_m_last got=%b exp=1", m_last); end
    tick(); #1;
    n_tests++; if (m_valid !== 4'b0000) begin n_fail++; $display("FAIL single_drain got=%b exp=0000", m_valid); end
  endtask

  task automatic test_packet_lane1();
    logic [DATA_W-1:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    m_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d[i], (i == 0) ? 2'd1 : 2'd3, (i == 3));
      #1;
      n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL pkt_s_ready beat=%0d got=%b exp=1", i, s_ready); end
      tick();
      n_tests++; if (m_valid !== 4'b0010) begin n_fail++; $display("FAIL pkt_m_valid beat=%0d got=%b exp=0010", i, m_valid); end
      n_tests++; if (m_data !== d[i]) begin n_fail++; $display("FAIL pkt_m_data beat=%0d got=%h exp=%h", i, m_data, d[i]); end
      n_tests++; if (m_last !== (i == 3)) begin n_fail++; $display("FAIL pkt_m_last beat=%0d got=%b exp=%b", i, m_last, (i == 3)); end
    end
    drive(1'b0, '0, 2'd0, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    m_ready = 4'b1110;
    drive(1'b1, d[0], 2'd0, 1'b0);
    tick();
    drive(1'b1, d[1], 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready stall=%0d got=%b exp=0", k, s_ready); end
      n_tests++; if (m_valid !== 4'b0001) begin n_fail++; $display("FAIL bp_m_valid stall=%0d got=%b exp=0001", k, m_valid); end
      n_tests++; if (m_data !== d[0]) begin n_fail++; $display("FAIL bp_m_data stall=%0d got=%h exp=%h", k, m_data, d[0]); end
      tick();
    end
    m_ready = 4'hF;
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, d[i], 2'd3, (i == 3));
      #1;
      n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume_ready beat=%0d got=%b exp=1", i, s_ready); end
      tick();
      n_tests++; if (m_valid !== 4'b0001 || m_data !== d[i]) begin n_fail++; $display("FAIL bp_resume beat=%0d got=%b/%h exp=0001/%h", i, m_valid, m_data, d[i]); end
    end
    drive(1'b0, '0, 2'd0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    m_ready = 4'hF;
    drive(1'b1, 8'h31, 2'd3, 1'b0); tick();
    drive(1'b1, 8'h32, 2'd1, 1'b0); tick();
    n_tests++; if (m_valid !== 4'b1000) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=1000", m_valid); end
    rst = 1'b1; drive(1'b0, '0, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (m_valid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_m_valid got=%b exp=0000", m_valid); end
    drive(1'b1, 8'h40, 2'd0, 1'b0); tick();
    n_tests++; if (m_valid !== 4'b0001 || m_data !== 8'h40) begin n_fail++; $display("FAIL rstmid_first got=%b/%h exp=0001/40", m_valid, m_data); end
    drive(1'b1, 8'h41, 2'd2, 1'b1); tick();
    n_tests++; if (m_valid !== 4'b0001 || m_last !== 1'b1) begin n_fail++; $display("FAIL rstmid_last got=%b/%b exp=0001/1", m_valid, m_last); end
    drive(1'b0, '0, 2'd0, 1'b0); tick();
  endtask

  task automatic test_counter_wrap();
    logic [4*CNT_W-1:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    m_ready = 4'hF;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, DATA_W'(i), 2'd2, 1'b1);
      tick();
    end
    drive(1'b0, '0, 2'd0, 1'b0);
    tick();
`ifdef DEMUX_CNT_EN
    exp = {CNT_W'(0), CNT_W'(1), CNT_W'(0), CNT_W'(0)};
`else
    exp = '0;
`endif
    n_tests++; if (cnt_flat !== exp) begin n_fail++; $display("FAIL cnt_wrap got=%h exp=%h", cnt_flat, exp); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      m_ready = 4'($urandom);
      drive(($urandom_range(0, 3) != 0), DATA_W'($urandom), 2'($urandom),
            ($urandom_range(0, 2) == 0));
      #1;
      n_tests++; if (s_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_s_ready cyc=%0d got=%b exp=%b", c, s_ready, exp_ready()); end
      n_tests++; if (m_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_m_valid cyc=%0d got=%b exp=%b", c, m_valid, exp_valid()); end
      if (mfull) begin
        n_tests++; if (m_data !== mdata || m_last !== mlast) begin n_fail++; $display("FAIL rnd_m_data cyc=%0d got=%h/%b exp=%h/%b", c, m_data, m_last, mdata, mlast); end
      end
      n_tests++; if (cnt_flat !== exp_cnt()) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%h exp=%h", c, cnt_flat, exp_cnt()); end
      tick();
    end
    drive(1'b0, '0, 2'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    m_ready = 4'hF;
    drive(1'b0, '0, 2'd0, 1'b0);
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_packet_lane1();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
